// File: rtl/speaker_arbiter_if.sv
`timescale 1ns/1ps
// speaker_arbiter_if
//  Groups the request/tone-operand inputs and the speaker/grant/status outputs
//  of speaker_arbiter. Clock and reset stay plain ports on the module.
//
//  Handshake: req[i] is a one-cycle strobe with no ready. A strobe is never
//  lost; it latches into a pending bit that merges repeats until the request
//  is granted, skipped (zero duration) or aborted by preemption/reset.
//  tone_half_per/tone_ms slices are only sampled in the cycle a request wins.
//
//  Signals
//   req            master->slave  one-cycle request strobes, index 0 = highest priority
//   tone_half_per  master->slave  per-requester half period (clocks), slice i = [i*HP_W +: HP_W]
//   tone_ms        master->slave  per-requester duration (ms), slice i = [i*MS_W +: MS_W]
//   mute           master->slave  blocks new grants and silences the speaker
//   speaker        slave->master  square-wave drive for the piezo pin
//   grant          slave->master  one-hot owner while a tone plays
//   busy           slave->master  tone playing or silent gap running
//   done           slave->master  one-cycle pulse when a tone completes or is skipped
//   state_dbg      slave->master  current FSM state (0 IDLE, 1 PLAY, 2 GAP)
interface speaker_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int HP_W    = 16,
  parameter int MS_W    = 10
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*HP_W-1:0] tone_half_per;
  logic [NUM_REQ*MS_W-1:0] tone_ms;
  logic                    mute;
  logic                    speaker;
  logic [NUM_REQ-1:0]      grant;
  logic                    busy;
  logic [NUM_REQ-1:0]      done;
  logic [1:0]              state_dbg;

  modport master (
    output req, tone_half_per, tone_ms, mute,
    input  speaker, grant, busy, done, state_dbg
  );

  modport slave (
    input  req, tone_half_per, tone_ms, mute,
    output speaker, grant, busy, done, state_dbg
  );
endinterface

// File: rtl/speaker_arbiter.sv
`timescale 1ns/1ps
// speaker_arbiter
//  Shares the single piezo speaker pin between game-event sound requesters.
//  One-cycle requests latch into pending bits; the lowest pending index wins,
//  its square-wave tone plays for tone_ms milliseconds, then a silent gap of
//  GAP_MS milliseconds follows before the next grant. A higher-priority
//  request can abort the running tone when ALLOW_PREEMPT is set.
//
//  Ports
//   clock   in   system clock (CLOCK_50)
//   resetn  in   asynchronous active-low reset
//   bus     slave modport of speaker_arbiter_if (requests, tone operands,
//                mute in; speaker, grant, busy, done, state_dbg out)
module speaker_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int CLK_HZ        = 50_000_000,
  parameter int HP_W          = 16,
  parameter int MS_W          = 10,
  parameter int GAP_MS        = 20,
  parameter int ALLOW_PREEMPT = 1
) (
  input logic              clock,
  input logic              resetn,
  speaker_arbiter_if.slave bus
);

  localparam int TICK  = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               speaker_q;
  logic               busy_q;
  logic               phase;
  logic [HP_W-1:0]    hp_cnt;
  logic [HP_W-1:0]    hp_reload;
  logic [MS_W-1:0]    ms_left;
  logic [PRE_W-1:0]   pre_cnt;
  logic [GAP_W-1:0]   gap_left;

  logic               win_vld;
  logic [NUM_REQ-1:0] win_oh;
  logic [HP_W-1:0]    win_hp;
  logic [MS_W-1:0]    win_ms;
  logic [NUM_REQ-1:0] take;
  logic [NUM_REQ-1:0] pending_nxt;
  logic               tick;
  logic               ms_last;
  logic               hp_wrap;
  logic               preempt;

  // Lowest pending index wins: scanning downwards lets the last hit stand.
  // The half period is clamped to 2 so the tone never degenerates to DC.
  always_comb begin
    win_vld = 1'b0;
    win_oh  = '0;
    win_hp  = '0;
    win_ms  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_vld = 1'b1;
        win_oh  = NUM_REQ'(1) << i;
        win_hp  = bus.tone_half_per[i*HP_W +: HP_W];
        win_ms  = bus.tone_ms[i*MS_W +: MS_W];
      end
    end
    if (win_hp < HP_W'(2)) win_hp = HP_W'(2);
  end

  always_comb begin
    take        = (state == S_IDLE && !bus.mute && win_vld) ? win_oh : '0;
    // A new strobe on the bit being granted this cycle re-arms it.
    pending_nxt = (pending & ~take) | bus.req;
    tick        = (pre_cnt == PRE_W'(TICK - 1));
    ms_last     = tick && (ms_left == MS_W'(1));
    hp_wrap     = (hp_cnt == HP_W'(1));
    // grant_q - 1 is a mask of every index above the owner in priority.
    preempt     = (ALLOW_PREEMPT != 0) && ((pending & (grant_q - 1'b1)) != '0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      pending   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
      phase     <= 1'b0;
      hp_cnt    <= '0;
      hp_reload <= '0;
      ms_left   <= '0;
      pre_cnt   <= '0;
      gap_left  <= '0;
    end else begin
      done_q  <= '0;
      pending <= pending_nxt;
      case (state)
        S_IDLE: begin
          speaker_q <= 1'b0;
          if (take != '0) begin
            if (win_ms == '0) begin
              done_q <= win_oh;
            end else begin
              state     <= S_PLAY;
              grant_q   <= win_oh;
              busy_q    <= 1'b1;
              hp_cnt    <= win_hp;
              hp_reload <= win_hp;
              ms_left   <= win_ms;
              pre_cnt   <= '0;
              phase     <= 1'b0;
            end
          end
        end
        S_PLAY: begin
          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
          if (tick) ms_left <= ms_left - 1'b1;
          if (hp_wrap) begin
            hp_cnt <= hp_reload;
            phase  <= ~phase;
          end else begin
            hp_cnt <= hp_cnt - 1'b1;
          end
          // The waveform phase keeps running under mute; only the pin is gated.
          speaker_q <= ~bus.mute & (phase ^ hp_wrap);
          if (ms_last) begin
            speaker_q <= 1'b0;
            grant_q   <= '0;
            done_q    <= grant_q;
            if (GAP_MS == 0) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              state    <= S_GAP;
              gap_left <= GAP_W'(GAP_MS);
            end
          end else if (preempt) begin
            // Aborted owner is dropped silently; the winner is picked in IDLE.
            state     <= S_IDLE;
            speaker_q <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
          end
        end
        S_GAP: begin
          speaker_q <= 1'b0;
          pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
          if (tick) begin
            gap_left <= gap_left - 1'b1;
            if (gap_left == GAP_W'(1)) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.speaker   = speaker_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_speaker_arbiter.sv
`timescale 1ns/1ps
// tb_speaker_arbiter
//  Directed bench for speaker_arbiter at 10 clocks per ms with a 2 ms gap.
//  dut_p allows preemption, dut_np does not. Grant and done events of dut_p
//  are checked against expected queues filled when requests are issued.
module tb_speaker_arbiter;

  logic clock;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;
  int   k = 0;

  logic [3:0] exp_grant_q[$];
  logic [3:0] exp_done_q[$];
  logic [3:0] prev_grant = '0;

  speaker_arbiter_if #(.NUM_REQ(4), .HP_W(16), .MS_W(10)) if_p ();
  speaker_arbiter_if #(.NUM_REQ(4), .HP_W(16), .MS_W(10)) if_np ();

  speaker_arbiter #(
    .NUM_REQ(4), .CLK_HZ(10_000), .HP_W(16), .MS_W(10), .GAP_MS(2), .ALLOW_PREEMPT(1)
  ) dut_p (
    .clock  (clock),
    .resetn (resetn),
    .bus    (if_p)
  );

  speaker_arbiter #(
    .NUM_REQ(4), .CLK_HZ(10_000), .HP_W(16), .MS_W(10), .GAP_MS(2), .ALLOW_PREEMPT(0)
  ) dut_np (
    .clock  (clock),
    .resetn (resetn),
    .bus    (if_np)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
    k++;
  endtask

  task automatic step_to(input int target);
    while (k < target) step();
  endtask

  task automatic set_tone(input int idx, input logic [15:0] hp, input logic [9:0] ms);
    if_p.tone_half_per[idx*16 +: 16]  = hp;
    if_p.tone_ms[idx*10 +: 10]        = ms;
    if_np.tone_half_per[idx*16 +: 16] = hp;
    if_np.tone_ms[idx*10 +: 10]       = ms;
  endtask

  task automatic pulse_req(input bit sel, input logic [3:0] v);
    if (sel) if_np.req = v; else if_p.req = v;
    step();
    if_p.req  = '0;
    if_np.req = '0;
  endtask

  // Request from idle; returns at the first PLAY cycle with k = 0.
  task automatic start_tone(input bit sel, input logic [3:0] v);
    pulse_req(sel, v);
    step();
    k = 0;
  endtask

  // ---------------- scoreboard monitor (dut_p) ----------------
  always @(negedge clock) begin
    if (resetn) begin
      if (if_p.done != '0) begin
        if (exp_done_q.size() == 0) check("sb_done_unexpected", 32'(if_p.done), 0);
        else check("sb_done", 32'(if_p.done), 32'(exp_done_q.pop_front()));
      end
      if (if_p.grant != '0 && if_p.grant != prev_grant) begin
        if (exp_grant_q.size() == 0) check("sb_grant_unexpected", 32'(if_p.grant), 0);
        else check("sb_grant", 32'(if_p.grant), 32'(exp_grant_q.pop_front()));
      end
    end
    prev_grant = if_p.grant;
  end

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0;
    if_p.req = '0;  if_p.tone_half_per = '0;  if_p.tone_ms = '0;  if_p.mute = 1'b0;
    if_np.req = '0; if_np.tone_half_per = '0; if_np.tone_ms = '0; if_np.mute = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_speaker", 32'(if_p.speaker), 0);
    check("rst_grant",   32'(if_p.grant), 0);
    check("rst_busy",    32'(if_p.busy), 0);
    check("rst_done",    32'(if_p.done), 0);
    resetn = 1'b1;
    step();
    check("rst_state", 32'(if_p.state_dbg), 0);

    // T1: reset in the middle of a tone
    set_tone(3, 5, 3);
    exp_grant_q.push_back(4'b1000);
    start_tone(0, 4'b1000);
    check("t1_grant", 32'(if_p.grant), 'h8);
    check("t1_busy",  32'(if_p.busy), 1);
    step_to(2);
    pulse_req(0, 4'b1000);
    step_to(5);
    check("t1_spk_hi", 32'(if_p.speaker), 1);
    resetn = 1'b0;
    #1;
    check("t1_rst_speaker", 32'(if_p.speaker), 0);
    check("t1_rst_grant",   32'(if_p.grant), 0);
    check("t1_rst_busy",    32'(if_p.busy), 0);
    check("t1_rst_done",    32'(if_p.done), 0);
    check("t1_rst_state",   32'(if_p.state_dbg), 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (5) step();
    check("t1_pending_lost_grant", 32'(if_p.grant), 0);
    check("t1_pending_lost_busy",  32'(if_p.busy), 0);

    // T2: single tone, half period 3, 4 ms
    set_tone(2, 3, 4);
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    start_tone(0, 4'b0100);
    for (int j = 0; j < 40; j++) begin
      check("t2_speaker", 32'(if_p.speaker), (j / 3) % 2);
      check("t2_grant",   32'(if_p.grant), 'h4);
      step();
    end
    check("t2_done",    32'(if_p.done), 'h4);
    check("t2_end_grant", 32'(if_p.grant), 0);
    check("t2_end_spk", 32'(if_p.speaker), 0);
    check("t2_gap_busy0", 32'(if_p.busy), 1);
    step();
    check("t2_done_one_cycle", 32'(if_p.done), 0);
    step_to(59);
    check("t2_gap_busy1", 32'(if_p.busy), 1);
    step();
    check("t2_idle_busy", 32'(if_p.busy), 0);

    // T3: simultaneous requests 1 and 3
    set_tone(1, 4, 2);
    set_tone(3, 2, 1);
    exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b1000);
    exp_done_q.push_back(4'b0010);
    exp_done_q.push_back(4'b1000);
    start_tone(0, 4'b1010);
    check("t3_first_grant", 32'(if_p.grant), 'h2);
    step_to(40);
    check("t3_between_grant", 32'(if_p.grant), 0);
    check("t3_between_busy",  32'(if_p.busy), 0);
    step();
    check("t3_second_grant", 32'(if_p.grant), 'h8);
    step_to(71);
    check("t3_idle_busy", 32'(if_p.busy), 0);

    // T4a: preemption of requester 3 by requester 0
    set_tone(3, 4, 3);
    set_tone(0, 2, 1);
    exp_grant_q.push_back(4'b1000);
    start_tone(0, 4'b1000);
    step_to(5);
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    pulse_req(0, 4'b0001);
    check("t4_spk_before", 32'(if_p.speaker), 1);
    check("t4_grant_before", 32'(if_p.grant), 'h8);
    step();
    check("t4_abort_grant", 32'(if_p.grant), 0);
    check("t4_abort_spk",   32'(if_p.speaker), 0);
    check("t4_abort_done",  32'(if_p.done), 0);
    check("t4_abort_busy",  32'(if_p.busy), 0);
    step();
    check("t4_new_grant", 32'(if_p.grant), 'h1);
    step_to(18);
    check("t4_done0", 32'(if_p.done), 'h1);
    step_to(38);
    check("t4_idle_busy", 32'(if_p.busy), 0);

    // T4b: same scenario without preemption
    start_tone(1, 4'b1000);
    step_to(5);
    pulse_req(1, 4'b0001);
    step_to(7);
    check("t4np_keep_grant", 32'(if_np.grant), 'h8);
    step_to(29);
    check("t4np_still_playing", 32'(if_np.grant), 'h8);
    step();
    check("t4np_done3", 32'(if_np.done), 'h8);
    step_to(50);
    check("t4np_gap_over", 32'(if_np.busy), 0);
    step();
    check("t4np_grant0", 32'(if_np.grant), 'h1);
    step_to(61);
    check("t4np_done0", 32'(if_np.done), 'h1);
    step_to(81);
    check("t4np_idle", 32'(if_np.busy), 0);

    // T5a: zero duration -> done only
    set_tone(1, 3, 0);
    exp_done_q.push_back(4'b0010);
    pulse_req(0, 4'b0010);
    check("t5_zero_pre_done", 32'(if_p.done), 0);
    step();
    check("t5_zero_done",  32'(if_p.done), 'h2);
    check("t5_zero_grant", 32'(if_p.grant), 0);
    check("t5_zero_busy",  32'(if_p.busy), 0);
    check("t5_zero_spk",   32'(if_p.speaker), 0);
    step();
    check("t5_zero_done_off", 32'(if_p.done), 0);
    check("t5_zero_state", 32'(if_p.state_dbg), 0);

    // T5b: half period 0 behaves as 2
    set_tone(2, 0, 1);
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    start_tone(0, 4'b0100);
    for (int j = 0; j < 10; j++) begin
      check("t5_hp0_speaker", 32'(if_p.speaker), (j / 2) % 2);
      step();
    end
    check("t5_hp0_done", 32'(if_p.done), 'h4);

    // T5c: repeated request while pending -> one tone
    set_tone(1, 3, 1);
    exp_grant_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0010);
    step_to(12);
    pulse_req(0, 4'b0010);
    step_to(15);
    pulse_req(0, 4'b0010);
    step_to(30);
    check("t5_merge_wait", 32'(if_p.grant), 0);
    step();
    check("t5_merge_grant", 32'(if_p.grant), 'h2);
    step_to(41);
    check("t5_merge_done", 32'(if_p.done), 'h2);
    step_to(71);
    check("t5_merge_single_grant", 32'(if_p.grant), 0);
    check("t5_merge_single_busy",  32'(if_p.busy), 0);

    // T6: mute
    set_tone(0, 2, 2);
    if_p.mute = 1'b1;
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    pulse_req(0, 4'b0001);
    for (int j = 0; j < 5; j++) begin
      step();
      check("t6_muted_grant", 32'(if_p.grant), 0);
    end
    if_p.mute = 1'b0;
    step();
    k = 0;
    check("t6_unmute_grant", 32'(if_p.grant), 'h1);
    step_to(3);
    check("t6_spk_hi", 32'(if_p.speaker), 1);
    if_p.mute = 1'b1;
    step();
    check("t6_mute_spk4", 32'(if_p.speaker), 0);
    step_to(6);
    check("t6_mute_spk6", 32'(if_p.speaker), 0);
    step();
    check("t6_mute_spk7", 32'(if_p.speaker), 0);
    step_to(19);
    check("t6_mute_grant", 32'(if_p.grant), 'h1);
    step();
    check("t6_mute_done", 32'(if_p.done), 'h1);
    check("t6_mute_end_grant", 32'(if_p.grant), 0);
    step_to(25);
    if_p.mute = 1'b0;
    step_to(40);
    check("t6_idle_busy", 32'(if_p.busy), 0);

    // Scoreboard drained
    step();
    check("sb_grant_left", 32'(exp_grant_q.size()), 0);
    check("sb_done_left",  32'(exp_done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
